shared_and_sched: RTL and testbench

Round-robin scheduler that shares one pipelined bitwise-AND unit among `NREQ` requesters. Each requester offers operand pairs over a valid/ready handshake. The scheduler grants at most one requester per cycle, pushes the operands through an internal `LAT`-stage AND pipeline, and returns the result tagged with a one-hot requester ID. It sits between the generated datapath clients and the single AND primitive, so one physical resource serves several logical `and` instructions.

---
 rtl/shared_and_sched.sv | 140 ++++++++++++++
 tb/tb_shared_and_sched.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/shared_and_sched.sv
// shared_and_sched
// Round-robin scheduler that shares one LAT-stage pipelined bitwise-AND unit
// among NREQ requesters. At most one requester is granted per cycle. Each
// result comes back LAT cycles later, tagged with the one-hot ID of the
// requester that issued it.
//
// Ports
//   clock      in   sole clock, rising edge
//   reset      in   asynchronous, active-high reset
//   en         in   issue enable; low blocks new grants, in-flight ops drain
//   req_valid  in   [NREQ]        per-requester operand valid
//   req_a      in   [NREQ*WIDTH]  operand a, requester i at [i*WIDTH +: WIDTH]
//   req_b      in   [NREQ*WIDTH]  operand b, same packing as req_a
//   req_ready  out  [NREQ]        one-hot or zero grant (combinational)
//   rsp_valid  out  [NREQ]        one-hot or zero result tag, one-cycle pulse
//   rsp_y      out  [WIDTH]       a & b, zero when no response
//   idle       out                no operation in flight
//   ops_done   out  [CNTW]        delivered-result count, wraps
module shared_and_sched #(
   parameter int NREQ  = 4,
   parameter int WIDTH = 8,
   parameter int LAT   = 2,
   parameter int CNTW  = 16
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  en,
   input  logic [NREQ-1:0]       req_valid,
   input  logic [NREQ*WIDTH-1:0] req_a,
   input  logic [NREQ*WIDTH-1:0] req_b,
   output logic [NREQ-1:0]       req_ready,
   output logic [NREQ-1:0]       rsp_valid,
   output logic [WIDTH-1:0]      rsp_y,
   output logic                  idle,
   output logic [CNTW-1:0]       ops_done
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   logic [PW-1:0]    r_ptr;
   logic             w_found;
   logic [PW-1:0]    w_gnt_idx;
   logic             w_take;
   logic [NREQ-1:0]  w_ready;
   logic [WIDTH-1:0] w_y;
   logic             w_busy;

   logic             r_vld_p [LAT];
   logic [NREQ-1:0]  r_id_p  [LAT];
   logic [WIDTH-1:0] r_y_p   [LAT];
   logic [CNTW-1:0]  r_ops;

   // Scan from r_ptr upward (wrapping) and pick the first valid requester.
   always_comb begin
      int            v_sum;
      logic [PW-1:0] v_idx;
      v_sum     = 0;
      v_idx     = '0;
      w_found   = 1'b0;
      w_gnt_idx = '0;
      for (int k = 0; k < NREQ; k++) begin
         v_sum = int'(r_ptr) + k;
         if (v_sum >= NREQ) begin
            v_sum = v_sum - NREQ;
         end
         v_idx = PW'(v_sum);
         if (!w_found && req_valid[v_idx]) begin
            w_found   = 1'b1;
            w_gnt_idx = v_idx;
         end
      end
   end

   assign w_take = en & w_found;

   // One-hot grant plus the AND of the granted requester's operands.
   always_comb begin
      w_ready = '0;
      w_y     = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (w_gnt_idx == PW'(i)) begin
            w_ready[i] = w_take;
            w_y        = req_a[i*WIDTH +: WIDTH] & req_b[i*WIDTH +: WIDTH];
         end
      end
   end

   assign req_ready = w_ready;

   // Pointer moves just past the requester that transferred; holds otherwise.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_ptr <= '0;
      end else if (w_take) begin
         r_ptr <= (w_gnt_idx == PW'(NREQ - 1)) ? '0 : w_gnt_idx + PW'(1);
      end
   end

   // ---- stage boundary: issue -> pipeline stage 1 .. LAT (control) ----
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         for (int s = 0; s < LAT; s++) begin
            r_vld_p[s] <= 1'b0;
         end
         r_ops <= '0;
      end else begin
         r_vld_p[0] <= w_take;
         for (int s = 1; s < LAT; s++) begin
            r_vld_p[s] <= r_vld_p[s-1];
         end
         if (r_vld_p[LAT-1]) begin
            r_ops <= r_ops + CNTW'(1);
         end
      end
   end

   // ---- stage boundary: issue -> pipeline stage 1 .. LAT (data) ----
   // Data carries no reset; every consumer is qualified by the stage valid.
   always_ff @(posedge clock) begin
      r_id_p[0] <= w_ready;
      r_y_p[0]  <= w_y;
      for (int s = 1; s < LAT; s++) begin
         r_id_p[s] <= r_id_p[s-1];
         r_y_p[s]  <= r_y_p[s-1];
      end
   end

   always_comb begin
      w_busy = 1'b0;
      for (int s = 0; s < LAT; s++) begin
         w_busy = w_busy | r_vld_p[s];
      end
   end

   assign rsp_valid = r_vld_p[LAT-1] ? r_id_p[LAT-1] : '0;
   assign rsp_y     = r_vld_p[LAT-1] ? r_y_p[LAT-1]  : '0;
   assign idle      = ~w_busy;
   assign ops_done  = r_ops;

endmodule

// File: tb/tb_shared_and_sched.sv
module tb_shared_and_sched;

   localparam int NREQ  = 4;
   localparam int WIDTH = 8;
   localparam int LAT   = 2;
   localparam int CNTW  = 16;
   localparam int CNTW2 = 4;

   logic                  clock = 1'b0;
   logic                  reset = 1'b1;
   logic                  en    = 1'b0;
   logic [NREQ-1:0]       req_valid = '0;
   logic [NREQ*WIDTH-1:0] req_a = '0;
   logic [NREQ*WIDTH-1:0] req_b = '0;

   logic [NREQ-1:0]  req_ready,   rsp_valid;
   logic [WIDTH-1:0] rsp_y;
   logic             idle;
   logic [CNTW-1:0]  ops_done;

   logic [NREQ-1:0]  req_ready_w, rsp_valid_w;
   logic [WIDTH-1:0] rsp_y_w;
   logic             idle_w;
   logic [CNTW2-1:0] ops_done_w;

   shared_and_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .CNTW(CNTW)) dut (
      .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_y(rsp_y), .idle(idle), .ops_done(ops_done)
   );

   // Same stimulus, narrow counter: exercises ops_done wrap-around.
   shared_and_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT), .CNTW(CNTW2)) dut_w (
      .clock(clock), .reset(reset), .en(en), .req_valid(req_valid),
      .req_a(req_a), .req_b(req_b), .req_ready(req_ready_w),
      .rsp_valid(rsp_valid_w), .rsp_y(rsp_y_w), .idle(idle_w), .ops_done(ops_done_w)
   );

   always #5 clock = ~clock;

   int cyc = 0;
   always @(posedge clock) cyc <= cyc + 1;

   typedef struct {
      logic [NREQ-1:0]  id;
      logic [WIDTH-1:0] y;
      int               due;
   } exp_t;

   exp_t exp_q[$];
   int   n_cmp   = 0;
   int   n_fail  = 0;
   int   m_ptr   = 0;
   int   m_count = 0;

   bit               busy [NREQ];
   logic [WIDTH-1:0] op_a [NREQ];
   logic [WIDTH-1:0] op_b [NREQ];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
      n_cmp++;
      if (act !== expv) begin
         n_fail++;
         $display("FAIL %s at cycle %0d: actual %0h required %0h", name, cyc, act, expv);
      end
   endtask

   task automatic drive();
      for (int i = 0; i < NREQ; i++) begin
         req_valid[i]              = busy[i];
         req_a[i*WIDTH +: WIDTH]   = op_a[i];
         req_b[i*WIDTH +: WIDTH]   = op_b[i];
      end
   endtask

   task automatic offer(input int i, input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      busy[i] = 1'b1;
      op_a[i] = a;
      op_b[i] = b;
      drive();
   endtask

   // One clock: optional random offers, reference round-robin decision at the
   // negedge, expected result queued, then requesters released on transfer.
   task automatic step(input bit auto_mode, input int pct);
      logic [NREQ-1:0] exp_rdy;
      int              sel;
      exp_t            e;
      if (auto_mode) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!busy[i] && $urandom_range(99) < pct) begin
               offer(i, WIDTH'($urandom_range(255)), WIDTH'($urandom_range(255)));
            end
         end
      end
      drive();
      @(negedge clock);
      exp_rdy = '0;
      sel     = -1;
      if (!reset && en) begin
         for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (m_ptr + k) % NREQ;
            if (sel < 0 && busy[i]) sel = i;
         end
      end
      if (sel >= 0) exp_rdy[sel] = 1'b1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      if (sel >= 0) begin
         e.id  = exp_rdy;
         e.y   = op_a[sel] & op_b[sel];
         e.due = cyc + LAT;
         exp_q.push_back(e);
         m_ptr = (sel + 1) % NREQ;
      end
      for (int i = 0; i < NREQ; i++) begin
         if (req_valid[i] && req_ready[i]) busy[i] = 1'b0;
      end
      @(posedge clock);
      #1;
      drive();
   endtask

   // Monitor: pops the scoreboard whenever a result is due and checks
   // response, idle and counters every cycle.
   always @(negedge clock) begin
      exp_t e;
      logic exp_idle;
      if (!reset) begin
         chk("ops_done", 32'(ops_done), 32'(m_count % (1 << CNTW)));
         chk("ops_done_wrap", 32'(ops_done_w), 32'(m_count % (1 << CNTW2)));
         exp_idle = 1'b1;
         foreach (exp_q[j]) begin
            if (exp_q[j].due - LAT < cyc) exp_idle = 1'b0;
         end
         chk("idle", 32'(idle), 32'(exp_idle));
         if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            e = exp_q.pop_front();
            chk("rsp_valid", 32'(rsp_valid), 32'(e.id));
            chk("rsp_y", 32'(rsp_y), 32'(e.y));
            m_count++;
         end else begin
            chk("rsp_valid_quiet", 32'(rsp_valid), 32'(0));
            chk("rsp_y_quiet", 32'(rsp_y), 32'(0));
         end
      end
   end

   initial begin
      for (int i = 0; i < NREQ; i++) begin
         busy[i] = 1'b0;
         op_a[i] = '0;
         op_b[i] = '0;
      end
      drive();
      repeat (3) @(posedge clock);
      #1;
      chk("reset_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("reset_rsp_y", 32'(rsp_y), 32'(0));
      chk("reset_idle", 32'(idle), 32'(1));
      chk("reset_ops_done", 32'(ops_done), 32'(0));
      reset = 1'b0;
      en    = 1'b1;

      // Single operation
      offer(0, 8'hF0, 8'h3C);
      repeat (5) step(0, 0);

      // All requesters contending, refilled every cycle
      for (int c = 0; c < 12; c++) begin
         for (int i = 0; i < NREQ; i++) begin
            if (!busy[i]) offer(i, 8'hFF, WIDTH'(i + 1));
         end
         step(0, 0);
      end
      repeat (4) step(0, 0);

      // Round-robin skip: grant 1, then only 0 and 3 contend
      offer(1, 8'h5A, 8'h0F);
      step(0, 0);
      for (int c = 0; c < 6; c++) begin
         if (!busy[0]) offer(0, 8'h81, WIDTH'(c));
         if (!busy[3]) offer(3, 8'h7E, WIDTH'(c + 8));
         step(0, 0);
      end
      repeat (4) step(0, 0);

      // Enable gating
      offer(0, 8'hC3, 8'hF0);
      step(0, 0);
      en = 1'b0;
      offer(2, 8'h3C, 8'h66);
      repeat (4) step(0, 0);
      en = 1'b1;
      step(0, 0);
      repeat (4) step(0, 0);

      // Reset mid-flight: ptr left at 2, op discarded, scan restarts at 0
      offer(1, 8'hAA, 8'hFF);
      step(0, 0);
      #2;
      reset = 1'b1;
      #1;
      chk("rst_now_rsp_valid", 32'(rsp_valid), 32'(0));
      chk("rst_now_rsp_y", 32'(rsp_y), 32'(0));
      chk("rst_now_idle", 32'(idle), 32'(1));
      chk("rst_now_ops_done", 32'(ops_done), 32'(0));
      exp_q.delete();
      m_ptr   = 0;
      m_count = 0;
      for (int i = 0; i < NREQ; i++) busy[i] = 1'b0;
      drive();
      @(posedge clock);
      #1;
      reset = 1'b0;
      offer(0, 8'h12, 8'h34);
      offer(3, 8'h56, 8'h78);
      repeat (6) step(0, 0);

      // Randomized traffic with random enable
      for (int c = 0; c < 400; c++) begin
         en = ($urandom_range(9) != 0);
         step(1, 60);
      end
      en = 1'b1;
      for (int c = 0; c < 20; c++) step(0, 0);

      chk("drain_queue_empty", 32'(exp_q.size()), 32'(0));
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
